// File: rtl/key_pkg.sv
// Shared definitions for the keypad event queue: FSM states, calculator key
// codes, and the raw-index-to-code decoder.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        RPT
    } key_state_t;

    localparam logic [4:0] KC_DIV = 5'h10;
    localparam logic [4:0] KC_MUL = 5'h11;
    localparam logic [4:0] KC_SUB = 5'h12;
    localparam logic [4:0] KC_ADD = 5'h13;
    localparam logic [4:0] KC_ESC = 5'h14;
    localparam logic [4:0] KC_ENT = 5'h15;
    localparam logic [4:0] KC_F4  = 5'h1A;
    localparam logic [4:0] KC_F3  = 5'h1B;
    localparam logic [4:0] KC_F2  = 5'h1C;
    localparam logic [4:0] KC_F1  = 5'h1D;
    localparam logic [4:0] KC_INV = 5'h1F;

    // Keypad is a 4x5 grid scanned row-major; digits sit in the middle columns.
    function automatic logic [4:0] map_key(input int unsigned idx);
        logic [4:0] code;
        code = KC_INV;
        case (idx)
            1:  code = KC_DIV;
            6:  code = KC_MUL;
            11: code = KC_SUB;
            16: code = KC_ADD;
            2:  code = KC_ESC;
            4:  code = KC_ENT;
            3:  code = 5'h00;
            7:  code = 5'h01;
            8:  code = 5'h02;
            9:  code = 5'h03;
            12: code = 5'h04;
            13: code = 5'h05;
            14: code = 5'h06;
            17: code = 5'h07;
            18: code = 5'h08;
            19: code = 5'h09;
            5:  code = KC_F4;
            10: code = KC_F3;
            15: code = KC_F2;
            20: code = KC_F1;
            default: code = KC_INV;
        endcase
        return code;
    endfunction

    function automatic logic is_repeatable(input logic [4:0] code);
        return (code <= 5'h09) || (code >= KC_DIV && code <= KC_ADD);
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word fall-through event FIFO; reports pushes lost to a full queue
// so the parent can keep a sticky overflow flag.
module key_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_drop
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (o_count == '0);
    assign full    = (o_count == CNT_W'(DEPTH));
    assign do_pop  = i_pop && !empty;
    // A pop on the same edge frees the slot the incoming push needs.
    assign do_push = i_push && (!full || do_pop);
    assign o_drop  = i_push && full && !do_pop;
    assign o_valid = !empty;
    assign o_data  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   o_count <= o_count + CNT_W'(1);
                2'b01:   o_count <= o_count - CNT_W'(1);
                default: o_count <= o_count;
            endcase
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// Turns the held-key level from the keypad scanner into press and auto-repeat
// events, decodes them to calculator codes and queues them for the consumer.
module key_event_queue #(
    parameter int KEY_W        = 5,
    parameter int DEPTH        = 4,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_DLY   = 25000000,
    parameter int REPEAT_PER   = 5000000,
    parameter int PASS_INVALID = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_key_valid,
    input  logic [KEY_W-1:0]           i_key_value,
    input  logic                       i_ready,
    input  logic                       i_clr_ovf,
    output logic                       o_valid,
    output logic [4:0]                 o_code,
    output logic                       o_repeat,
    output logic                       o_is_digit,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_overflow
);
    import key_pkg::*;

    localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER - 1);

    logic             prev_valid;
    logic [KEY_W-1:0] key_reg;
    key_state_t       state;
    key_state_t       state_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press;
    logic [4:0]       press_code;
    logic [4:0]       held_code;
    logic             fire;
    logic             fire_rep;
    logic [4:0]       fire_code;
    logic             ev_valid;
    logic [5:0]       ev_data;
    logic [5:0]       fifo_head;
    logic             fifo_drop;

    assign press      = i_key_valid && (!prev_valid || (i_key_value != key_reg));
    assign press_code = map_key(32'(i_key_value));
    assign held_code  = map_key(32'(key_reg));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = hold_cnt;
        fire      = 1'b0;
        fire_rep  = 1'b0;
        fire_code = held_code;
        if (!i_key_valid) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (press) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
            fire      = 1'b1;
            fire_code = press_code;
        end else begin
            case (state)
                // Control keys park in HELD without counting until release.
                HELD: begin
                    if (REPEAT_EN != 0 && is_repeatable(held_code)) begin
                        if (hold_cnt == DLY_LAST) begin
                            fire      = 1'b1;
                            fire_rep  = 1'b1;
                            state_nxt = RPT;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = hold_cnt + CNT_W'(1);
                        end
                    end
                end
                RPT: begin
                    if (hold_cnt == PER_LAST) begin
                        fire     = 1'b1;
                        fire_rep = 1'b1;
                        cnt_nxt  = '0;
                    end else begin
                        cnt_nxt = hold_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prev_valid <= 1'b0;
            key_reg    <= '0;
            state      <= IDLE;
            hold_cnt   <= '0;
        end else begin
            prev_valid <= i_key_valid;
            if (i_key_valid) begin
                key_reg <= i_key_value;
            end
            state    <= state_nxt;
            hold_cnt <= cnt_nxt;
        end
    end

    // Unmapped keys die here so they never cost a FIFO slot.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ev_valid   <= 1'b0;
            ev_data    <= '0;
            o_overflow <= 1'b0;
        end else begin
            ev_valid <= fire && ((PASS_INVALID != 0) || (fire_code != KC_INV));
            ev_data  <= {fire_rep, fire_code};
            if (fifo_drop) begin
                o_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                o_overflow <= 1'b0;
            end
        end
    end

    key_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (6)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (ev_valid),
        .i_data  (ev_data),
        .i_pop   (i_ready),
        .o_valid (o_valid),
        .o_data  (fifo_head),
        .o_count (o_count),
        .o_drop  (fifo_drop)
    );

    assign o_code     = fifo_head[4:0];
    assign o_repeat   = fifo_head[5];
    assign o_is_digit = o_valid && (fifo_head[4:0] <= 5'h09);

endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Successor to the keypad key-to-code mapper. It turns the raw keypad index stream into discrete press events and decodes each to the calculator code set.
- Adds level-to-event press detection, hold auto-repeat, a parametrised event FIFO with a valid/ready output, and sticky overflow.
- Sits between the keypad scanner and the calculator/display control FSM, which drains events at its own pace.

Parameters:
- KEY_W, 5, raw key index width.
- DEPTH, 4, event FIFO depth (power of two, ≥2).
- REPEAT_EN, 1, enable hold auto-repeat.
- REPEAT_DLY, 25000000, cycles a key must be held before the first repeat event.
- REPEAT_PER, 5000000, cycles between subsequent repeat events.
- PASS_INVALID, 0, 1 = enqueue unmapped keys as code 0x1F; 0 = drop them.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-high reset
- i_key_valid  in  1  level, high while a key is held; i_key_value is stable while high
- i_key_value  in  KEY_W  raw key index, 1..20
- i_ready  in  1  consumer accepts the head event
- i_clr_ovf  in  1  one-cycle pulse, clears o_overflow
- o_valid  out  1  FIFO non-empty (head event present)
- o_code  out  5  head event code
- o_repeat  out  1  head event came from auto-repeat
- o_is_digit  out  1  head code is 0x00..0x09
- o_count  out  $clog2(DEPTH+1)  current FIFO occupancy
- o_overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While i_rst is high, all outputs are 0, the FIFO is empty, the FSM is in IDLE and the prev-valid register is 0.
- Map (index->code):
  - 1->0x10 (/), 6->0x11 (x), 11->0x12 (-), 16->0x13 (+).
  - 2->0x14 (ESC), 4->0x15 (ENT).
  - 3->0x00; 7,8,9->0x01..0x03; 12,13,14->0x04..0x06; 17,18,19->0x07..0x09.
  - 5->0x1A (F4), 10->0x1B (F3), 15->0x1C (F2), 20->0x1D (F1).
  - Any other index->0x1F (invalid).
- Press event: generated at any edge where i_key_valid=1 and either prev_valid=0, or i_key_value differs from the registered value.
- FSM states IDLE, HELD, RPT; counter hold_cnt is sized $clog2(max(REPEAT_DLY,REPEAT_PER)+1).
  - IDLE: on a press event -> HELD, hold_cnt=0.
  - HELD: hold_cnt increments each cycle. When hold_cnt reaches REPEAT_DLY-1: emit a repeat event, go to RPT, hold_cnt=0.
  - RPT: when hold_cnt reaches REPEAT_PER-1: emit a repeat event, hold_cnt=0.
  - Any state: i_key_valid=0 -> IDLE. A value change -> new press event, HELD, hold_cnt=0.
  - Repeat applies only to digits and operators (0x00..0x09, 0x10..0x13). For ESC, ENT, F-keys and invalid, the FSM stays in HELD and emits nothing further.
  - REPEAT_EN=0: HELD is terminal until release.
- Latency: the edge that detects an event registers {code, repeat} into an event register. The FIFO write happens on the next edge. With an empty FIFO, o_valid rises 2 cycles after i_key_valid is first sampled high.
- Invalid keys: dropped at the event register when PASS_INVALID=0, so no FIFO write occurs.
- FIFO behaviour:
  - First-word fall-through: o_code, o_repeat and o_is_digit reflect the head whenever o_valid=1.
  - A pop occurs on an edge with o_valid & i_ready.
  - Push when full without a simultaneous pop: the event is dropped, o_overflow is set, and FIFO contents are unchanged.
  - Push and pop on the same edge while full: both are accepted and the count is unchanged.
  - Push and pop on the same edge while empty: push only, because o_valid was 0.
  - Pointers wrap modulo DEPTH.
- Overflow flag: i_clr_ovf clears o_overflow. If clear and a new overflow occur on the same edge, set wins.
- Reset mid-operation: the FIFO is flushed and o_overflow is cleared. A key still held when i_rst deasserts yields exactly one press event, because prev_valid resets to 0.

Decomposition:
- Package key_pkg:
  - Code constants: KC_DIV, KC_MUL, KC_SUB, KC_ADD, KC_ESC, KC_ENT, KC_F1..KC_F4, KC_INV=5'h1F.
  - Function map_key(index)->code.
  - Function is_repeatable(code).
- Sub-module key_event_fifo, parametrised by DEPTH and data width 6 ({repeat, code}), owning the pointers, count, and full/empty logic.
- The top level holds edge detection, the FSM, hold_cnt, the event register and the overflow flag.

Test Plan (REPEAT_DLY=8, REPEAT_PER=4, DEPTH=4, i_ready=1 unless stated):
- Reset/idle: i_rst high with i_key_valid=1, value 7 -> all outputs 0. Release reset with the key still held -> exactly one event, o_code=0x01, o_repeat=0, o_valid high 2 cycles after release.
- Full map: hold each index 1..20 for 2 cycles, separated by 2 idle cycles -> the codes sequence matches the table. Index 0 and index 25 produce no event (PASS_INVALID=0), or 0x1F (PASS_INVALID=1).
- Auto-repeat: hold index 13 for 20 cycles -> press event, then repeat events with code 0x05 and o_repeat=1 at 8, 12, 16 cycles after the press detection edge. Hold index 4 (ENT) for 20 cycles -> a single 0x15 event.
- Value change while held: i_key_valid stays high, value goes 8->9 -> events 0x02 then 0x03, and hold_cnt restarts.
- Overflow: i_ready=0, 5 distinct presses -> o_count=4, o_overflow=1, and the head is still the first code. A pulse of i_clr_ovf clears the flag. A full FIFO with a simultaneous push and pop keeps o_count=4 with correct ordering.
- Drain ordering: push 3 events, then toggle i_ready 1,0,1,1 -> the codes pop in FIFO order and o_count decrements only on edges where i_ready=1.
